wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
//  Dual-lane writeback stage: last pipeline stage, directly upstream of the 4R/2W byte-enable register file.
//  Registers the two-lane MEM bus, aligns load data (LB/LBU/LH/LHU/LW/LWL/LWR) and produces per-lane 4-bit byte enables.
//  Merges a same-cycle same-register WAW so lane 1 sees lane 0's bytes, and serialises both lanes into a single-port debug trace through a small FIFO.
// PARAMETERS
//  DBG_DEPTH   4   debug trace FIFO entries; power of two, >= 2
// PORTS
//  clk                 in   1   clock
//  reset               in   1   synchronous, active-high
//  ms_to_ws_valid      in   1   MEM bus valid
//  ms_lane1_valid      in   1   lane 1 carries an instruction; ignored unless ms_to_ws_valid
//  ws_allow_in         out  1   WB accepts the bus this cycle
//  ms_pc0/ms_pc1       in   32  lane PCs
//  ms_rf_we0/1         in   1   lane writes a GPR
//  ms_rf_waddr0/1      in   5   destination GPR
//  ms_res0/1           in   32  ALU result; for loads, the old rt value (LWL/LWR merge)
//  ms_ld_op0/1         in   3   0 none,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 LWL,7 LWR
//  ms_ld_off0/1        in   2   load address [1:0]
//  ms_ld_rdata0/1      in   32  raw word read from data RAM
//  rf_we0/rf_we1       out  4   byte write enables to register file
//  rf_waddr0/1         out  5   register file write address
//  rf_wdata0/1         out  32  register file write data
//  debug_wb_pc         out  32  trace PC
//  debug_wb_rf_wen     out  4   trace byte enables
//  debug_wb_rf_wnum    out  5   trace register number
//  debug_wb_rf_wdata   out  32  trace data (full merged word)
// BEHAVIOUR
//  - State: ws_valid, ws_lane1, latched bus, DBG_DEPTH-entry FIFO {pc,wen,wnum,wdata}, rd/wr pointers, count.
//  - reset: ws_valid=0, FIFO empty. All rf_* and debug_* outputs read 0. Nothing is written; anything in flight is dropped.
//  - n = 1 + ws_lane1. free = DBG_DEPTH - count + (count != 0) (this cycle's pop counted).
//  - ws_ready_go = (free >= n). commit = ws_valid & ws_ready_go.
//  - ws_allow_in = !ws_valid | ws_ready_go. On ms_to_ws_valid & ws_allow_in: latch bus, ws_valid=1.
//  - Otherwise, on commit: ws_valid=0.
//  - Load align (k = off): LB/LBU sign/zero-extend byte k. LH/LHU use halfword k[1] (k[0] assumed 0, no check). LW: whole word.
//  - LWL: we = {1, k>=1, k>=2, k==3}; wdata = rdata << 8*(3-k).
//  - LWR: we = {k==0, k<=1, k<=2, 1}; wdata = rdata >> 8*k.
//  - LWL/LWR bytes not enabled take ms_res; the debug wdata is that merged word.
//  - Non-load: we = 4'hf when ms_rf_we, data = ms_res.
//  - we forced 0 when !commit, !ms_rf_we, waddr==0, or lane 1 absent. Outputs are combinational from latched state (0-cycle).
//  - WAW merge: both lanes we!=0 and waddr0==waddr1 -> rf_we0=0. rf_we1 = we0|we1.
//    rf_wdata1 byte b = we1[b] ? lane1[b] : lane0[b]. Bytes that neither lane enables are not written.
//  - Trace: every committed instruction pushes one entry (also wen=0), lane 0 before lane 1, in the commit cycle.
//  - Trace pop: the head shows on debug_* and pops every cycle while count>0, else 0.
//    Lane 0 appears 1 cycle after commit, lane 1 2 cycles after.
//  - Push and pop in the same cycle are both legal; count never exceeds DBG_DEPTH. Pointers wrap modulo DBG_DEPTH.
//  - Stall: with the FIFO full, a dual commit needs free>=2. WB holds and outputs rf_we=0 until then; no bus is lost or duplicated.
// TESTING
//  - Reset held 3 cycles with bus valid -> rf_we*=0, debug_wb_pc=0, ws_allow_in=1 on the first cycle after release.
//  - Lane0 LWL off=1, rdata=0xAABBCCDD, res=0x11223344 -> rf_we0=4'b1100, rf_wdata0[31:16]=0xCCDD.
//    Next cycle: debug wdata=0xCCDD3344, wen=4'b1100.
//  - Lane0 LB off=3, rdata=0x80xxxxxx -> wdata 0xFFFFFF80, we 4'hf. LBU same input -> wdata 0x00000080.
//  - Dual: lane0 ALU r5=0x01020304; lane1 LWR off=2 r5, rdata=0xAABBCCDD -> rf_we0=0, rf_we1=4'hf, rf_wdata1=0x0102AABB.
//    Trace: r5=0x01020304, then r5=0x0102AABB.
//  - Back-to-back dual bundles every cycle, DBG_DEPTH=4 -> ws_allow_in low every other cycle after fill, exactly one trace per cycle, PC order preserved.
//  - Lane waddr=0 with ms_rf_we=1 -> rf_we=0; trace still emits its pc with wen=0.

Source files
------------

// File: rtl/wb_stage.sv
// Dual-lane writeback stage: latches the MEM bus, aligns load data, merges same-register
// writes between lanes and serialises committed instructions into a debug trace FIFO.
module wb_stage #(
    parameter int DBG_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ms_to_ws_valid,
    input  logic        ms_lane1_valid,
    output logic        ws_allow_in,

    input  logic [31:0] ms_pc0,
    input  logic [31:0] ms_pc1,
    input  logic        ms_rf_we0,
    input  logic        ms_rf_we1,
    input  logic [4:0]  ms_rf_waddr0,
    input  logic [4:0]  ms_rf_waddr1,
    input  logic [31:0] ms_res0,
    input  logic [31:0] ms_res1,
    input  logic [2:0]  ms_ld_op0,
    input  logic [2:0]  ms_ld_op1,
    input  logic [1:0]  ms_ld_off0,
    input  logic [1:0]  ms_ld_off1,
    input  logic [31:0] ms_ld_rdata0,
    input  logic [31:0] ms_ld_rdata1,

    output logic [3:0]  rf_we0,
    output logic [3:0]  rf_we1,
    output logic [4:0]  rf_waddr0,
    output logic [4:0]  rf_waddr1,
    output logic [31:0] rf_wdata0,
    output logic [31:0] rf_wdata1,

    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    localparam int PW = (DBG_DEPTH > 1) ? $clog2(DBG_DEPTH) : 1;
    localparam int CW = $clog2(DBG_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DBG_DEPTH);

    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_LW  = 3'd5;
    localparam logic [2:0] OP_LWL = 3'd6;
    localparam logic [2:0] OP_LWR = 3'd7;

    // Returns {byte_mask, merged_word}; bytes outside the mask keep the old rt value.
    function automatic logic [35:0] ld_align(
        input logic [2:0]  op,
        input logic [1:0]  k,
        input logic [31:0] rdata,
        input logic [31:0] res
    );
        logic [7:0]  byte_k;
        logic [15:0] half_k;
        logic [31:0] shifted;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        partial;
        byte_k  = 8'(rdata >> {k, 3'b000});
        half_k  = k[1] ? rdata[31:16] : rdata[15:0];
        shifted = '0;
        mask    = 4'hf;
        data    = res;
        partial = 1'b0;
        case (op)
            OP_LB:  data = {{24{byte_k[7]}}, byte_k};
            OP_LBU: data = {24'h0, byte_k};
            OP_LH:  data = {{16{half_k[15]}}, half_k};
            OP_LHU: data = {16'h0, half_k};
            OP_LW:  data = rdata;
            OP_LWL: begin
                mask    = {1'b1, k >= 2'd1, k >= 2'd2, k == 2'd3};
                shifted = rdata << {~k, 3'b000};
                partial = 1'b1;
            end
            OP_LWR: begin
                mask    = {k == 2'd0, k <= 2'd1, k <= 2'd2, 1'b1};
                shifted = rdata >> {k, 3'b000};
                partial = 1'b1;
            end
            default: data = res;
        endcase
        if (partial) begin
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) data[8*b +: 8] = shifted[8*b +: 8];
            end
        end
        return {mask, data};
    endfunction

    logic        ws_valid;
    logic        ws_lane1;
    logic [31:0] pc0_q, pc1_q;
    logic        we0_q, we1_q;
    logic [4:0]  waddr0_q, waddr1_q;
    logic [31:0] res0_q, res1_q;
    logic [2:0]  op0_q, op1_q;
    logic [1:0]  off0_q, off1_q;
    logic [31:0] rdata0_q, rdata1_q;

    logic [31:0] fifo_pc    [DBG_DEPTH];
    logic [3:0]  fifo_wen   [DBG_DEPTH];
    logic [4:0]  fifo_wnum  [DBG_DEPTH];
    logic [31:0] fifo_wdata [DBG_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, wr_ptr_p1;
    logic [CW-1:0] count;

    logic        pop;
    logic [CW:0] free;
    logic [1:0]  n_need;
    logic        ready_go;
    logic        commit;
    logic        push0, push1;
    logic [1:0]  n_push;

    logic [3:0]  mask0, mask1;
    logic [31:0] data0, data1;
    logic [3:0]  lane_we0, lane_we1;
    logic        waw;

    // The head leaves this cycle, so its slot is already usable for a push.
    assign pop       = (count != '0);
    assign free      = DEPTH_C - {1'b0, count} + {{CW{1'b0}}, pop};
    assign n_need    = ws_lane1 ? 2'd2 : 2'd1;
    assign ready_go  = (free >= {{(CW - 1){1'b0}}, n_need});
    assign commit    = ws_valid & ready_go;
    assign ws_allow_in = ~ws_valid | ready_go;

    assign push0     = commit;
    assign push1     = commit & ws_lane1;
    assign n_push    = {push1, push0 & ~push1};
    assign wr_ptr_p1 = wr_ptr + PW'(1);

    assign {mask0, data0} = ld_align(op0_q, off0_q, rdata0_q, res0_q);
    assign {mask1, data1} = ld_align(op1_q, off1_q, rdata1_q, res1_q);

    assign lane_we0 = (commit && we0_q && waddr0_q != 5'd0) ? mask0 : 4'h0;
    assign lane_we1 = (commit && ws_lane1 && we1_q && waddr1_q != 5'd0) ? mask1 : 4'h0;
    assign waw      = (lane_we0 != 4'h0) && (lane_we1 != 4'h0) && (waddr0_q == waddr1_q);

    assign rf_waddr0 = waddr0_q;
    assign rf_waddr1 = waddr1_q;
    assign rf_wdata0 = data0;

    // On a same-register collision lane 1 carries both lanes' bytes in one write.
    always_comb begin
        rf_we0    = lane_we0;
        rf_we1    = lane_we1;
        rf_wdata1 = data1;
        if (waw) begin
            rf_we0 = 4'h0;
            rf_we1 = lane_we0 | lane_we1;
            for (int b = 0; b < 4; b++) begin
                if (!lane_we1[b]) rf_wdata1[8*b +: 8] = data0[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid <= 1'b0;
            ws_lane1 <= 1'b0;
            pc0_q    <= '0;
            pc1_q    <= '0;
            we0_q    <= 1'b0;
            we1_q    <= 1'b0;
            waddr0_q <= '0;
            waddr1_q <= '0;
            res0_q   <= '0;
            res1_q   <= '0;
            op0_q    <= '0;
            op1_q    <= '0;
            off0_q   <= '0;
            off1_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (ms_to_ws_valid && ws_allow_in) begin
            ws_valid <= 1'b1;
            ws_lane1 <= ms_lane1_valid;
            pc0_q    <= ms_pc0;
            pc1_q    <= ms_pc1;
            we0_q    <= ms_rf_we0;
            we1_q    <= ms_rf_we1;
            waddr0_q <= ms_rf_waddr0;
            waddr1_q <= ms_rf_waddr1;
            res0_q   <= ms_res0;
            res1_q   <= ms_res1;
            op0_q    <= ms_ld_op0;
            op1_q    <= ms_ld_op1;
            off0_q   <= ms_ld_off0;
            off1_q   <= ms_ld_off1;
            rdata0_q <= ms_ld_rdata0;
            rdata1_q <= ms_ld_rdata1;
        end else if (commit) begin
            ws_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            wr_ptr <= wr_ptr + PW'(n_push);
            count  <= count - CW'(pop) + CW'(n_push);
        end
    end

    // Lane 0's entry records its own write; lane 1's records the merged write.
    always_ff @(posedge clk) begin
        if (!reset && push0) begin
            fifo_pc[wr_ptr]    <= pc0_q;
            fifo_wen[wr_ptr]   <= lane_we0;
            fifo_wnum[wr_ptr]  <= waddr0_q;
            fifo_wdata[wr_ptr] <= data0;
        end
        if (!reset && push1) begin
            fifo_pc[wr_ptr_p1]    <= pc1_q;
            fifo_wen[wr_ptr_p1]   <= rf_we1;
            fifo_wnum[wr_ptr_p1]  <= waddr1_q;
            fifo_wdata[wr_ptr_p1] <= rf_wdata1;
        end
    end

    always_comb begin
        debug_wb_pc       = '0;
        debug_wb_rf_wen   = '0;
        debug_wb_rf_wnum  = '0;
        debug_wb_rf_wdata = '0;
        if (pop) begin
            debug_wb_pc       = fifo_pc[rd_ptr];
            debug_wb_rf_wen   = fifo_wen[rd_ptr];
            debug_wb_rf_wnum  = fifo_wnum[rd_ptr];
            debug_wb_rf_wdata = fifo_wdata[rd_ptr];
        end
    end

endmodule
